// File: rtl/debounce_func_value.sv
// Front-end helper for the Simpson's-rule integrator: a push-button debouncer
// that emits one registered enable pulse per accepted press, and a purely
// combinational cubic polynomial evaluator (Horner form, modulo 2^WIDTH).
module debounce_func_value #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn,
    output logic             enable,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] value
);

    // Counter value on which the next differing sample completes the
    // debounce window.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    // Two-flop synchronizer for the asynchronous button.
    logic             s1_q;
    logic             s2_q;
    // Accepted (debounced) level and its one-cycle delayed copy.
    logic             stable_q;
    logic             stable_d;
    logic             stable_dly_q;
    // Run length of samples that disagree with the accepted level.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    // Registered press pulse.
    logic             enable_q;
    logic             enable_d;

    // Horner evaluation; every intermediate is truncated to WIDTH bits, so
    // the result is the exact polynomial reduced modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] horner(
        input logic [WIDTH-1:0] c0,
        input logic [WIDTH-1:0] c1,
        input logic [WIDTH-1:0] c2,
        input logic [WIDTH-1:0] c3,
        input logic [WIDTH-1:0] xv
    );
        logic [WIDTH-1:0] acc;
        acc = c3 * xv + c2;
        acc = acc * xv + c1;
        acc = acc * xv + c0;
        return acc;
    endfunction

    // Debounce counter and acceptance decision, plus rising-edge pulse.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = {CNT_W{1'b0}};
        if (s2_q == stable_q) begin
            // A return to the accepted level discards any partial window.
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q == LAST_CNT) begin
            stable_d = s2_q;
            cnt_d    = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Pulse one cycle after the accepted level rises; releases and
        // holds never produce a pulse.
        enable_d = stable_q & ~stable_dly_q;
    end

    // Synchronizer, debounce state and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            cnt_q        <= {CNT_W{1'b0}};
            enable_q     <= 1'b0;
        end else begin
            s1_q         <= btn;
            s2_q         <= s1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            enable_q     <= enable_d;
        end
    end

    // Evaluator output is combinational: the consumer samples it the cycle
    // after it registers x, so no pipeline stage may be inserted here.
    always_comb begin
        value = horner(a0, a1, a2, a3, x);
    end

    assign enable = enable_q;

endmodule

// File: tb/tb_debounce_func_value.sv
// Self-checking bench for debounce_func_value: directed and randomized button
// sequences against a window-based reference model, plus polynomial vectors
// against a full-precision sum-of-powers reference.
module tb_debounce_func_value;

    localparam int W = 16;
    localparam int S = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         btn = 1'b0;
    logic         enable;
    logic [W-1:0] a0 = '0;
    logic [W-1:0] a1 = '0;
    logic [W-1:0] a2 = '0;
    logic [W-1:0] a3 = '0;
    logic [W-1:0] x  = '0;
    logic [W-1:0] value;

    int errors = 0;
    int checks = 0;

    // Reference model state: raw button history (two leading zeros stand for
    // the reset contents of the synchronizer), accepted level, pending pulse.
    bit hist[$];
    bit stable_m;
    bit rise_m;
    int cyc;
    int pulses;
    int last_pulse_cyc;
    int last_rise_cyc;

    debounce_func_value #(.WIDTH(W), .STABLE_CYCLES(S), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .btn(btn), .enable(enable),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .x(x), .value(value)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
        stable_m = 1'b0;
        rise_m   = 1'b0;
        cyc      = 0;
    endtask

    // One clock with btn=b. A level is accepted once the last S synchronized
    // samples all differ from the accepted level; a rise pulses next cycle.
    task automatic step(input bit b);
        bit exp_en;
        bit acc;
        int n;
        if (b && !btn) last_rise_cyc = cyc + 1;
        btn = b;
        @(posedge clk);
        exp_en = rise_m;
        rise_m = 1'b0;
        hist.push_back(b);
        n = hist.size();
        acc = (n - 2 >= S);
        if (acc) begin
            for (int j = 0; j < S; j++) begin
                if (hist[n-3-j] == stable_m) acc = 1'b0;
            end
        end
        if (acc) begin
            stable_m = ~stable_m;
            rise_m   = stable_m;
        end
        cyc++;
        @(negedge clk);
        checks++;
        assert (enable === exp_en) else begin
            errors++;
            $error("FAIL enable cyc=%0d observed=%b expected=%b", cyc, enable, exp_en);
        end
        if (enable === 1'b1) begin
            pulses++;
            last_pulse_cyc = cyc;
        end
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b);
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs == expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reset applied asynchronously between edges; enable must drop at once.
    task automatic do_reset(input bit b);
        btn = b;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        assert (enable === 1'b0) else begin
            errors++;
            $error("FAIL reset_async observed=%b expected=0", enable);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            assert (enable === 1'b0) else begin
                errors++;
                $error("FAIL reset_hold observed=%b expected=0", enable);
            end
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [W-1:0] poly_ref(input logic [W-1:0] c0, input logic [W-1:0] c1,
                                               input logic [W-1:0] c2, input logic [W-1:0] c3,
                                               input logic [W-1:0] xv);
        longint unsigned xl;
        longint unsigned r;
        xl = 64'(xv);
        r  = 64'(c0) + 64'(c1) * xl + 64'(c2) * xl * xl + 64'(c3) * xl * xl * xl;
        return r[W-1:0];
    endfunction

    task automatic check_poly(input string tag, input logic [W-1:0] c0, input logic [W-1:0] c1,
                              input logic [W-1:0] c2, input logic [W-1:0] c3,
                              input logic [W-1:0] xv, input logic [W-1:0] expv);
        a0 = c0; a1 = c1; a2 = c2; a3 = c3; x = xv;
        #1;
        checks++;
        assert (value === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, value, expv);
        end
    endtask

    initial begin
        logic [W-1:0] r0, r1, r2, r3, rx;
        model_reset();
        pulses = 0;
        last_pulse_cyc = -1;
        last_rise_cyc = 0;

        // Evaluator, exercised while the debouncer is held in reset.
        btn = 1'b1;
        #3;
        checks++;
        assert (enable === 1'b0) else begin
            errors++;
            $error("FAIL reset_initial observed=%b expected=0", enable);
        end
        check_poly("poly_x0",   16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 16'd1);
        check_poly("poly_x1",   16'd1, 16'd2, 16'd3, 16'd4, 16'd1, 16'd10);
        check_poly("poly_x2",   16'd1, 16'd2, 16'd3, 16'd4, 16'd2, 16'd49);
        check_poly("poly_const", 16'd5, 16'd0, 16'd0, 16'd0, 16'd1234, 16'd5);
        check_poly("poly_cube_wrap", 16'd0, 16'd0, 16'd0, 16'd1, 16'd41, 16'd3385);
        check_poly("poly_lin_wrap", 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd2, 16'hFFFE);
        for (int i = 0; i <= 10; i++) begin
            check_poly("poly_square", 16'd0, 16'd0, 16'd1, 16'd0, W'(i), W'(i * i));
        end
        for (int i = 0; i < 40; i++) begin
            r0 = W'($urandom); r1 = W'($urandom); r2 = W'($urandom);
            r3 = W'($urandom); rx = W'($urandom);
            check_poly("poly_rand", r0, r1, r2, r3, rx, poly_ref(r0, r1, r2, r3, rx));
        end

        // Button held through reset release: one pulse after S+3 cycles.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        pulses = 0;
        hold(1'b1, 25);
        check_int("reset_release_pulses", pulses, 1);
        check_int("reset_release_latency", last_pulse_cyc, S + 3);

        // Held button: a single pulse, then release and press for a second.
        hold(1'b0, 20);
        pulses = 0;
        hold(1'b1, 100);
        check_int("held_pulses", pulses, 1);
        hold(1'b0, 20);
        pulses = 0;
        hold(1'b1, 20);
        check_int("repress_pulses", pulses, 1);

        // Bounce rejection: toggle every 3 cycles, then settle high.
        hold(1'b0, 20);
        pulses = 0;
        for (int i = 0; i < 40; i++) step(((i / 3) % 2) == 1);
        hold(1'b1, 30);
        check_int("bounce_press_pulses", pulses, 1);
        checks++;
        assert ((last_pulse_cyc - last_rise_cyc >= S + 2) &&
                (last_pulse_cyc - last_rise_cyc <= S + 4)) else begin
            errors++;
            $error("FAIL bounce_latency observed=%0d expected=%0d+-1",
                   last_pulse_cyc - last_rise_cyc, S + 3);
        end
        pulses = 0;
        for (int i = 0; i < 30; i++) step(((i / 3) % 2) == 0);
        hold(1'b0, 30);
        check_int("bounce_release_pulses", pulses, 0);

        // Reset in the middle of a press window: no pulse, then re-accept.
        hold(1'b1, 5);
        pulses = 0;
        do_reset(1'b1);
        hold(1'b1, 25);
        check_int("midcount_reset_pulses", pulses, 1);
        check_int("midcount_reset_latency", last_pulse_cyc, S + 3);

        // Randomized runs of random length, checked cycle by cycle.
        for (int k = 0; k < 60; k++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 14));
        end
        hold(1'b0, 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
